// File: rtl/uart_csr_bridge_if.sv
// Byte-stream and CSR bus signals between uart_csr_bridge, its uart_transceiver and the CSR responder.
// master = the bridge; slave = the environment (transceiver + CSR responder).
interface uart_csr_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (
    input  rx_data, rx_done, tx_done, csr_do,
    output tx_data, tx_wr, csr_a, csr_we, csr_di
  );

  modport slave (
    output rx_data, rx_done, tx_done, csr_do,
    input  tx_data, tx_wr, csr_a, csr_we, csr_di
  );
endinterface

// File: rtl/uart_csr_bridge.sv
// Serial-host CSR initiator: parses write/read command frames from the uart rx stream and replies on tx.
// Optional inter-byte gap timeout enabled by defining UART_CSR_BRIDGE_TIMEOUT_EN.
module uart_csr_bridge #(
  parameter logic [7:0] ack_byte = 8'hAA
`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned timeout_cycles = 1000000
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  uart_csr_bridge_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA, CSR_WR, CSR_RD, RD_CAP, TX_SEND, TX_WAIT
  } state_e;

  state_e      state_q;
  logic        op_wr_q;
  logic [1:0]  byte_cnt_q;
  logic [2:0]  tx_left_q;
  logic [31:0] shreg_q;
  logic [13:0] csr_a_q;
  logic        csr_we_q;
  logic [31:0] csr_di_q;
  logic [7:0]  tx_data_q;
  logic        tx_wr_q;
`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
  logic [31:0] gap_q;
`endif

  assign bus.csr_a   = csr_a_q;
  assign bus.csr_we  = csr_we_q;
  assign bus.csr_di  = csr_di_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_wr   = tx_wr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      tx_left_q  <= '0;
      csr_a_q    <= '0;
      csr_we_q   <= 1'b0;
      csr_di_q   <= '0;
      tx_data_q  <= '0;
      tx_wr_q    <= 1'b0;
`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
      gap_q      <= '0;
`endif
    end else begin
      csr_we_q <= 1'b0;
      tx_wr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_done && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02)) begin
            op_wr_q <= (bus.rx_data == 8'h01);
            state_q <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (bus.rx_done) begin
            csr_a_q[13:8] <= bus.rx_data[5:0];
            state_q       <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (bus.rx_done) begin
            csr_a_q[7:0] <= bus.rx_data;
            byte_cnt_q   <= '0;
            state_q      <= op_wr_q ? DATA : CSR_RD;
          end
        end
        DATA: begin
          if (bus.rx_done) begin
            csr_di_q   <= {csr_di_q[23:0], bus.rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              csr_we_q <= 1'b1;
              state_q  <= CSR_WR;
            end
          end
        end
        CSR_WR: begin
          tx_data_q <= ack_byte;
          tx_wr_q   <= 1'b1;
          tx_left_q <= '0;
          state_q   <= TX_WAIT;
        end
        CSR_RD: state_q <= RD_CAP;
        // tx_wr/tx_data are raised on entry so they are valid during the TX_SEND cycle itself
        RD_CAP: begin
          shreg_q   <= bus.csr_do;
          tx_data_q <= bus.csr_do[31:24];
          tx_wr_q   <= 1'b1;
          tx_left_q <= 3'd4;
          state_q   <= TX_SEND;
        end
        TX_SEND: begin
          shreg_q   <= {shreg_q[23:0], 8'h00};
          tx_left_q <= tx_left_q - 3'd1;
          state_q   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.tx_done && !tx_wr_q) begin
            if (tx_left_q != 3'd0) begin
              tx_data_q <= shreg_q[31:24];
              tx_wr_q   <= 1'b1;
              state_q   <= TX_SEND;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
      // A received byte always wins over an expiring gap in the same cycle
      if (state_q == ADDR_HI || state_q == ADDR_LO || state_q == DATA) begin
        if (bus.rx_done) begin
          gap_q <= '0;
        end else if (gap_q == timeout_cycles - 1) begin
          gap_q      <= '0;
          byte_cnt_q <= '0;
          state_q    <= IDLE;
        end else begin
          gap_q <= gap_q + 32'd1;
        end
      end else begin
        gap_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Bench for uart_csr_bridge: registered CSR responder, tx model answering tx_done 10 cycles after tx_wr,
// directed frames followed by randomized frames checked against a frame-level reference model.
module tb_uart_csr_bridge;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  uart_csr_bridge_if bus ();

`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
  uart_csr_bridge #(.ack_byte(8'hAA), .timeout_cycles(100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus)
  );
`else
  uart_csr_bridge #(.ack_byte(8'hAA)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus)
  );
`endif

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Power-on contents of the CSR space seen by both the responder and the reference model
  function automatic logic [31:0] init_val(input logic [13:0] a);
    if (a == 14'h0402) return 32'h12345678;
    return {a, 2'b10, a, 2'b01} ^ 32'hA5C3_0F96;
  endfunction

  logic [31:0] mem [0:16383];
  bit          wr_seen [0:16383];
  always @(posedge sys_clk) begin
    if (bus.csr_we === 1'b1) begin
      mem[bus.csr_a]     <= bus.csr_di;
      wr_seen[bus.csr_a] <= 1'b1;
    end
    bus.csr_do <= wr_seen[bus.csr_a] ? mem[bus.csr_a] : init_val(bus.csr_a);
  end

  int tx_cnt = 0;
  always @(posedge sys_clk) begin
    bus.tx_done <= 1'b0;
    if (bus.tx_wr === 1'b1) tx_cnt <= 10;
    else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) bus.tx_done <= 1'b1;
    end
  end

  typedef struct { logic [13:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { logic [7:0] b; int c; } tx_t;
  wr_t wr_q [$];
  tx_t tx_q [$];
  int  inflight_viol = 0;

  always @(negedge sys_clk) begin
    if (bus.csr_we === 1'b1) wr_q.push_back('{bus.csr_a, bus.csr_di, cyc});
    if (bus.tx_wr === 1'b1) begin
      if (tx_cnt != 0) inflight_viol++;
      tx_q.push_back('{bus.tx_data, cyc});
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int wr_rd    = 0;
  int tx_rd    = 0;
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [13:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output int lbl);
    @(negedge sys_clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    lbl = cyc;
    @(negedge sys_clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a1, input logic [7:0] a0, input logic [31:0] d,
                          input int gap, output int lbl);
    logic [7:0] fr [7];
    fr = '{8'h01, a1, a0, d[31:24], d[23:16], d[15:8], d[7:0]};
    for (int i = 0; i < 7; i++) begin
      send_byte(fr[i], lbl);
      idle(gap);
    end
  endtask

  task automatic do_read(input logic [7:0] a1, input logic [7:0] a0, input int gap, output int lbl);
    logic [7:0] fr [3];
    fr = '{8'h02, a1, a0};
    for (int i = 0; i < 3; i++) begin
      send_byte(fr[i], lbl);
      if (i < 2) idle(gap);
    end
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 400) begin
      @(negedge sys_clk);
      k++;
    end
    check({tag, " tx count"}, 64'(tx_q.size()), 64'(n));
  endtask

  task automatic expect_write(input logic [13:0] a, input logic [31:0] d, input int lbl, input string tag);
    wait_tx(tx_rd + 1, tag);
    idle(15);
    check({tag, " we pulses"}, 64'(wr_q.size()), 64'(wr_rd + 1));
    if (wr_q.size() > wr_rd) begin
      check({tag, " csr_a"}, 64'(wr_q[wr_rd].a), 64'(a));
      check({tag, " csr_di"}, 64'(wr_q[wr_rd].d), 64'(d));
      check({tag, " we latency"}, 64'(wr_q[wr_rd].c), 64'(lbl + 1));
    end
    if (tx_q.size() > tx_rd) begin
      check({tag, " ack byte"}, 64'(tx_q[tx_rd].b), 64'(8'hAA));
      check({tag, " ack latency"}, 64'(tx_q[tx_rd].c), 64'(lbl + 2));
    end
    wr_rd = wr_q.size();
    tx_rd = tx_q.size();
    ref_mem[int'(a)] = d;
  endtask

  task automatic expect_read(input logic [13:0] a, input int lbl, input string tag);
    logic [31:0] exp;
    exp = ref_rd(a);
    wait_tx(tx_rd + 4, tag);
    idle(15);
    check({tag, " no we"}, 64'(wr_q.size()), 64'(wr_rd));
    check({tag, " tx total"}, 64'(tx_q.size()), 64'(tx_rd + 4));
    if (tx_q.size() >= tx_rd + 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("%s byte%0d", tag, i), 64'(tx_q[tx_rd + i].b), 64'(exp[31 - 8*i -: 8]));
      check({tag, " first tx latency"}, 64'(tx_q[tx_rd].c), 64'(lbl + 3));
    end
    check({tag, " tx overlap"}, 64'(inflight_viol), 64'(0));
    wr_rd = wr_q.size();
    tx_rd = tx_q.size();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " csr_a"},   64'(bus.csr_a),   64'(0));
    check({tag, " csr_we"},  64'(bus.csr_we),  64'(0));
    check({tag, " csr_di"},  64'(bus.csr_di),  64'(0));
    check({tag, " tx_data"}, 64'(bus.tx_data), 64'(0));
    check({tag, " tx_wr"},   64'(bus.tx_wr),   64'(0));
  endtask

  int lbl;
  initial begin
    logic [7:0]  a1, a0, jb;
    logic [31:0] d;
    logic [13:0] last_wa;
    int          gap, nj;
    sys_rst     = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    last_wa     = 14'h0005;
    idle(3);
    check_outputs_zero("reset");
    sys_rst = 1'b0;
    idle(2);
    check_outputs_zero("after reset");

    do_write(8'h00, 8'h05, 32'hDEADBEEF, 0, lbl);
    expect_write(14'h0005, 32'hDEADBEEF, lbl, "write");

    do_read(8'h04, 8'h02, 0, lbl);
    expect_read(14'h0402, lbl, "read");

    send_byte(8'h7F, lbl);
    do_read(8'hC0, 8'h01, 1, lbl);
    expect_read(14'h0001, lbl, "junk+mask");
    check("junk+mask csr_a", 64'(bus.csr_a), 64'(14'h0001));

    do_read(8'h04, 8'h02, 0, lbl);
    begin
      int l2, base;
      base = tx_rd;
      wait_tx(base + 1, "overlap first");
      send_byte(8'h01, l2);
    end
    expect_read(14'h0402, lbl, "overlap read");
    do_write(8'h12, 8'h34, 32'hCAFEF00D, 0, lbl);
    expect_write(14'h1234, 32'hCAFEF00D, lbl, "overlap write");

    begin
      logic [7:0] part [5];
      part = '{8'h01, 8'h00, 8'h05, 8'hDE, 8'hAD};
      for (int i = 0; i < 5; i++) send_byte(part[i], lbl);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_outputs_zero("mid-frame reset");
    sys_rst = 1'b0;
    idle(20);
    check("reset no we", 64'(wr_q.size()), 64'(wr_rd));
    check("reset no tx", 64'(tx_q.size()), 64'(tx_rd));
    do_read(8'h00, 8'h05, 0, lbl);
    expect_read(14'h0005, lbl, "read after reset");

    for (int t = 0; t < 12; t++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom_range(3, 255));
        send_byte(jb, lbl);
      end
      a1  = 8'($urandom);
      a0  = 8'($urandom);
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a1, a0, d, gap, lbl);
        expect_write({a1[5:0], a0}, d, lbl, $sformatf("rnd%0d write", t));
        last_wa = {a1[5:0], a0};
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          a1 = {2'($urandom), last_wa[13:8]};
          a0 = last_wa[7:0];
        end
        do_read(a1, a0, gap, lbl);
        expect_read({a1[5:0], a0}, lbl, $sformatf("rnd%0d read", t));
      end
    end

`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
    send_byte(8'h01, lbl);
    send_byte(8'h00, lbl);
    send_byte(8'h05, lbl);
    idle(105);
    check("timeout no we", 64'(wr_q.size()), 64'(wr_rd));
    check("timeout no tx", 64'(tx_q.size()), 64'(tx_rd));
    do_read(8'h00, 8'h05, 0, lbl);
    expect_read(14'h0005, lbl, "read after timeout");
`endif

    check("final tx overlap", 64'(inflight_viol), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
